// File: rtl/io_header.sv
// rtl/io_header.sv - shared IO map constants, access sizes and bridge FSM states
package io_header;

    localparam logic [23:0] IO_BASE_HI_DEF = 24'hFFFFFC;
    localparam logic [7:0]  IN_BASE        = 8'h00;
    localparam logic [7:0]  BTN_OFF        = 8'h70;
    localparam logic [7:0]  OUT_BASE       = 8'h80;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_IO_RD = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    // IO registers only accept full words; memory follows natural alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a,
                                           input logic io);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = a[0];
            SZ_WORD: bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        if (io && (size != SZ_WORD)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - per-bit two-flop synchronizer with synchronous active-low reset
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - load/store bridge to data memory and a small memory-mapped IO region
module mem_io_bridge
    import io_header::*;
#(
    parameter logic [23:0] IO_BASE_HI = IO_BASE_HI_DEF,
    parameter int          N_IN       = 4,
    parameter int          N_OUT      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m_read,
    input  logic                  m_write,
    input  logic [1:0]            mem_size,
    input  logic [31:0]           addr,
    input  logic [31:0]           st_data,
    input  logic [31:0]           m_rdata,
    input  logic [32*N_IN-1:0]    in_data,
    input  logic                  btn_raw,
    output logic [31:0]           addr_out,
    output logic                  m_wen,
    output logic [3:0]            byte_en,
    output logic [31:0]           write_data,
    output logic [31:0]           r_wdata,
    output logic [32*N_OUT-1:0]   out_data,
    output logic [N_OUT-1:0]      out_strobe,
    output logic                  stall,
    output logic                  addr_err
);

    logic [32*N_IN-1:0]  in_sync;
    logic                btn_sync;

    sync_2ff #(.WIDTH(32*N_IN)) u_sync_in (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in_data),
        .q     (in_sync)
    );

    sync_2ff #(.WIDTH(1)) u_sync_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (btn_sync)
    );

    state_e              state_q, state_d;
    logic [31:0]         rd_buf_q, rd_buf_d;
    logic                rd_btn_q, rd_btn_d;
    logic                btn_prev_q;
    logic                btn_flag_q, btn_flag_d;
    logic [32*N_OUT-1:0] out_data_q, out_data_d;
    logic [N_OUT-1:0]    out_strobe_q, out_strobe_d;
    logic                addr_err_q, addr_err_d;

    logic [7:0]          offset;
    logic                is_io;
    logic                misaligned;
    logic                idle;
    logic                wr_req;
    logic                btn_rise;
    logic [N_IN-1:0]     in_hit;
    logic [N_OUT-1:0]    out_hit;
    logic                btn_hit;
    logic                rd_mapped;
    logic [31:0]         rd_val;
    logic                io_rd_ok;
    logic                io_wr_ok;
    logic                mem_rd;
    logic                mem_wr;
    logic [31:0]         rdata_shift;

    assign offset     = addr[7:0];
    assign is_io      = (addr[31:8] == IO_BASE_HI);
    assign misaligned = is_misaligned(mem_size, addr[1:0], is_io);
    assign idle       = (state_q == ST_IDLE);
    // A simultaneous read and write keeps the read and drops the write.
    assign wr_req     = m_write & ~m_read;
    assign btn_rise   = btn_sync & ~btn_prev_q;

    always_comb begin
        in_hit  = '0;
        out_hit = '0;
        rd_val  = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (offset == (IN_BASE + 8'(4*k))) begin
                in_hit[k] = 1'b1;
                rd_val    = in_sync[32*k +: 32];
            end
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (offset == (OUT_BASE + 8'(4*k))) begin
                out_hit[k] = 1'b1;
                rd_val     = out_data_q[32*k +: 32];
            end
        end
        btn_hit = (offset == BTN_OFF);
        if (btn_hit) begin
            rd_val = {31'b0, btn_flag_q};
        end
    end

    assign rd_mapped = (|in_hit) | (|out_hit) | btn_hit;
    assign io_rd_ok  = idle & m_read & is_io & ~misaligned & rd_mapped;
    assign io_wr_ok  = idle & wr_req & is_io & ~misaligned & (|out_hit);
    assign mem_rd    = idle & m_read & ~is_io & ~misaligned;
    assign mem_wr    = idle & wr_req & ~is_io & ~misaligned;

    always_comb begin
        state_d      = state_q;
        rd_buf_d     = rd_buf_q;
        rd_btn_d     = rd_btn_q;
        btn_flag_d   = btn_flag_q;
        out_data_d   = out_data_q;
        out_strobe_d = '0;
        addr_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (io_rd_ok) begin
                    state_d  = ST_IO_RD;
                    rd_buf_d = rd_val;
                    rd_btn_d = btn_hit;
                end
            end
            ST_IO_RD: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // A fresh edge landing in the clear cycle must not be lost.
        if (btn_rise) begin
            btn_flag_d = 1'b1;
        end else if ((state_q == ST_RESP) && rd_btn_q) begin
            btn_flag_d = 1'b0;
        end

        if (io_wr_ok) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (out_hit[k]) begin
                    out_data_d[32*k +: 32] = st_data;
                    out_strobe_d[k]        = 1'b1;
                end
            end
        end

        if (idle && (m_read || m_write)) begin
            if (misaligned || (m_read && m_write)) begin
                addr_err_d = 1'b1;
            end else if (is_io && m_read && !rd_mapped) begin
                addr_err_d = 1'b1;
            end else if (is_io && !m_read && !(|out_hit)) begin
                addr_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rd_buf_q     <= '0;
            rd_btn_q     <= 1'b0;
            btn_prev_q   <= 1'b0;
            btn_flag_q   <= 1'b0;
            out_data_q   <= '0;
            out_strobe_q <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_buf_q     <= rd_buf_d;
            rd_btn_q     <= rd_btn_d;
            btn_prev_q   <= btn_sync;
            btn_flag_q   <= btn_flag_d;
            out_data_q   <= out_data_d;
            out_strobe_q <= out_strobe_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign rdata_shift = m_rdata >> {addr[1:0], 3'b000};

    always_comb begin
        byte_en    = 4'b0000;
        write_data = '0;
        if (mem_wr) begin
            case (mem_size)
                SZ_BYTE: begin
                    byte_en    = 4'b0001 << addr[1:0];
                    write_data = {4{st_data[7:0]}};
                end
                SZ_HALF: begin
                    byte_en    = 4'b0011 << addr[1:0];
                    write_data = {2{st_data[15:0]}};
                end
                default: begin
                    byte_en    = 4'b1111;
                    write_data = st_data;
                end
            endcase
        end
    end

    always_comb begin
        r_wdata = '0;
        if (state_q == ST_RESP) begin
            r_wdata = rd_buf_q;
        end else if (mem_rd) begin
            case (mem_size)
                SZ_BYTE: r_wdata = {24'b0, rdata_shift[7:0]};
                SZ_HALF: r_wdata = {16'b0, rdata_shift[15:0]};
                default: r_wdata = m_rdata;
            endcase
        end
    end

    assign addr_out   = addr;
    assign m_wen      = mem_wr;
    assign stall      = io_rd_ok | (state_q == ST_IO_RD);
    assign out_data   = out_data_q;
    assign out_strobe = out_strobe_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - directed table-driven and sequence checks for mem_io_bridge
module tb_mem_io_bridge;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                m_read, m_write;
    logic [1:0]          mem_size;
    logic [31:0]         addr, st_data, m_rdata;
    logic [32*N_IN-1:0]  in_data;
    logic                btn_raw;
    logic [31:0]         addr_out;
    logic                m_wen;
    logic [3:0]          byte_en;
    logic [31:0]         write_data, r_wdata;
    logic [32*N_OUT-1:0] out_data;
    logic [N_OUT-1:0]    out_strobe;
    logic                stall, addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_io_bridge #(.IO_BASE_HI(24'hFFFFFC), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_read     (m_read),
        .m_write    (m_write),
        .mem_size   (mem_size),
        .addr       (addr),
        .st_data    (st_data),
        .m_rdata    (m_rdata),
        .in_data    (in_data),
        .btn_raw    (btn_raw),
        .addr_out   (addr_out),
        .m_wen      (m_wen),
        .byte_en    (byte_en),
        .write_data (write_data),
        .r_wdata    (r_wdata),
        .out_data   (out_data),
        .out_strobe (out_strobe),
        .stall      (stall),
        .addr_err   (addr_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdat;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rw;
        logic        err;
    } vec_t;

    vec_t vecs[14];

    task automatic idle_bus();
        m_read   = 1'b0;
        m_write  = 1'b0;
        mem_size = 2'b10;
        addr     = 32'h0;
        st_data  = 32'h0;
        m_rdata  = 32'h0;
    endtask

    // Caller is #1 after a posedge; returns #1 after the edge leaving RESP.
    task automatic io_read(input string name, input logic [31:0] a, input logic [31:0] exp,
                           input logic raise_btn);
        m_read   = 1'b1;
        mem_size = 2'b10;
        addr     = a;
        if (raise_btn) btn_raw = 1'b1;
        @(negedge clk);
        check({name, " stall c0"}, 64'(stall), 64'd1);
        check({name, " rdata c0"}, 64'(r_wdata), 64'd0);
        @(posedge clk); #1;
        btn_raw = 1'b0;
        @(negedge clk);
        check({name, " stall c1"}, 64'(stall), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, " stall c2"}, 64'(stall), 64'd0);
        check({name, " rdata c2"}, 64'(r_wdata), 64'(exp));
        @(posedge clk); #1;
        m_read = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1, 0, 2'b10, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0};
        vecs[1]  = '{0, 1, 2'b00, 32'h0000_0003, 32'h0000_00A5, 32'h0, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0};
        vecs[2]  = '{0, 1, 2'b01, 32'h0000_0002, 32'h1234_BEEF, 32'h0, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0};
        vecs[3]  = '{0, 1, 2'b10, 32'h0000_0008, 32'h1234_5678, 32'h0, 1, 4'b1111, 32'h1234_5678, 32'h0, 0};
        vecs[4]  = '{1, 0, 2'b00, 32'h0000_0001, 32'h0, 32'h1122_3344, 0, 4'b0000, 32'h0, 32'h0000_0033, 0};
        vecs[5]  = '{1, 0, 2'b01, 32'h0000_0002, 32'h0, 32'h1122_3344, 0, 4'b0000, 32'h0, 32'h0000_1122, 0};
        vecs[6]  = '{1, 0, 2'b01, 32'h0000_0001, 32'h0, 32'h1122_3344, 0, 4'b0000, 32'h0, 32'h0, 1};
        vecs[7]  = '{1, 0, 2'b10, 32'h0000_0006, 32'h0, 32'h1122_3344, 0, 4'b0000, 32'h0, 32'h0, 1};
        vecs[8]  = '{1, 0, 2'b11, 32'h0000_0000, 32'h0, 32'h1122_3344, 0, 4'b0000, 32'h0, 32'h0, 1};
        vecs[9]  = '{1, 1, 2'b10, 32'h0000_0010, 32'h5555_5555, 32'hCAFE_F00D, 0, 4'b0000, 32'h0, 32'hCAFE_F00D, 1};
        vecs[10] = '{1, 0, 2'b00, 32'hFFFF_FC00, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1};
        vecs[11] = '{1, 0, 2'b10, 32'hFFFF_FC40, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1};
        vecs[12] = '{0, 1, 2'b10, 32'hFFFF_FC88, 32'h7777_7777, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1};
        vecs[13] = '{0, 0, 2'b10, 32'h0000_0020, 32'h9999_9999, 32'h8888_8888, 0, 4'b0000, 32'h0, 32'h0, 0};

        rst_n   = 1'b0;
        in_data = '0;
        btn_raw = 1'b0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset stall", 64'(stall), 64'd0);
        check("reset out_data", out_data, 64'h0);
        check("reset out_strobe", 64'(out_strobe), 64'd0);
        check("reset addr_err", 64'(addr_err), 64'd0);
        check("reset r_wdata", 64'(r_wdata), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            m_read   = vecs[i].rd;
            m_write  = vecs[i].wr;
            mem_size = vecs[i].sz;
            addr     = vecs[i].a;
            st_data  = vecs[i].sd;
            m_rdata  = vecs[i].rdat;
            @(negedge clk);
            check($sformatf("v%0d m_wen", i), 64'(m_wen), 64'(vecs[i].wen));
            check($sformatf("v%0d byte_en", i), 64'(byte_en), 64'(vecs[i].be));
            check($sformatf("v%0d write_data", i), 64'(write_data), 64'(vecs[i].wd));
            check($sformatf("v%0d r_wdata", i), 64'(r_wdata), 64'(vecs[i].rw));
            check($sformatf("v%0d stall", i), 64'(stall), 64'd0);
            check($sformatf("v%0d addr_out", i), 64'(addr_out), 64'(vecs[i].a));
            @(posedge clk); #1;
            check($sformatf("v%0d addr_err", i), 64'(addr_err), 64'(vecs[i].err));
        end
        idle_bus();
        @(posedge clk); #1;
        check("addr_err one cycle", 64'(addr_err), 64'd0);

        // Input channel read with held request through the stall.
        in_data[63:32] = 32'h0000_0ABC;
        repeat (3) @(posedge clk);
        #1;
        io_read("in ch1", 32'hFFFF_FC04, 32'h0000_0ABC, 1'b0);
        @(negedge clk);
        check("after io read r_wdata", 64'(r_wdata), 64'd0);
        check("after io read stall", 64'(stall), 64'd0);

        // Output channel write.
        @(posedge clk); #1;
        m_write  = 1'b1;
        mem_size = 2'b10;
        addr     = 32'hFFFF_FC84;
        st_data  = 32'h0000_FFFF;
        @(negedge clk);
        check("io wr m_wen", 64'(m_wen), 64'd0);
        check("io wr stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        idle_bus();
        check("io wr out_data", out_data, 64'h0000_FFFF_0000_0000);
        check("io wr strobe", 64'(out_strobe), 64'd2);
        check("io wr addr_err", 64'(addr_err), 64'd0);
        @(posedge clk); #1;
        check("io wr strobe end", 64'(out_strobe), 64'd0);
        check("io wr out_data hold", out_data, 64'h0000_FFFF_0000_0000);
        io_read("out ch1 rd", 32'hFFFF_FC84, 32'h0000_FFFF, 1'b0);

        // Button flag: set, read-clear, then edge racing the clear.
        btn_raw = 1'b1;
        @(posedge clk); #1;
        btn_raw = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        io_read("btn rd1", 32'hFFFF_FC70, 32'd1, 1'b0);
        io_read("btn rd2", 32'hFFFF_FC70, 32'd0, 1'b0);
        btn_raw = 1'b1;
        @(posedge clk); #1;
        btn_raw = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        io_read("btn rd3", 32'hFFFF_FC70, 32'd1, 1'b1);
        io_read("btn rd4", 32'hFFFF_FC70, 32'd1, 1'b0);
        io_read("btn rd5", 32'hFFFF_FC70, 32'd0, 1'b0);

        // Reset while in IO_RD abandons the read.
        m_read   = 1'b1;
        mem_size = 2'b10;
        addr     = 32'hFFFF_FC04;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre-reset stall", 64'(stall), 64'd1);
        rst_n  = 1'b0;
        m_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst mid stall", 64'(stall), 64'd0);
        check("rst mid r_wdata", 64'(r_wdata), 64'd0);
        check("rst mid out_data", out_data, 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst mid stall c2", 64'(stall), 64'd0);
        check("rst mid r_wdata c2", 64'(r_wdata), 64'd0);

        @(posedge clk); #1;
        m_read   = 1'b1;
        mem_size = 2'b01;
        addr     = 32'h0000_0001;
        @(negedge clk);
        check("half mis stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        idle_bus();
        check("half mis addr_err", 64'(addr_err), 64'd1);
        @(posedge clk); #1;
        check("half mis addr_err end", 64'(addr_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter IO_BASE_HI, default 24'hFFFFFC, meaning addr[31:8] value selecting the IO region.
REQ-002 SHALL have parameter N_IN, default 4, meaning input-device channels, 1..16.
REQ-003 SHALL have parameter N_OUT, default 2, meaning output-device channels, 1..16.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  reset, synchronous, active-low
  m_read  in  1  load request
  m_write  in  1  store request
  mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved
  addr  in  32  ALU-computed address
  st_data  in  32  store data from register file
  m_rdata  in  32  data memory read data, lane-aligned word
  in_data  in  32*N_IN  raw input-device words, channel k at bits [32k+31:32k]
  btn_raw  in  1  raw confirm button
  addr_out  out  32  equals addr
  m_wen  out  1  data memory write enable
  byte_en  out  4  memory byte-lane enables
  write_data  out  32  lane-shifted store data
  r_wdata  out  32  load data to register file
  out_data  out  32*N_OUT  output-device registers
  out_strobe  out  N_OUT  one-cycle update pulse per channel
  stall  out  1  pipeline hold request
  addr_err  out  1  one-cycle error pulse

Function
REQ-005 SHALL classify an access as IO when addr[31:8]==IO_BASE_HI, otherwise memory.
REQ-006 SHALL map IO offsets: input k at 8'h00+4k (k<N_IN), button status at 8'h70, output k at 8'h80+4k (k<N_OUT); other offsets unmapped.
REQ-007 SHALL flag misalignment: half with addr[0]=1, word with addr[1:0]!=0, mem_size=11; any IO access other than word size is misaligned.
REQ-008 SHALL drive m_wen = m_write & memory & aligned, combinationally.
REQ-009 SHALL drive byte_en combinationally: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; 0 when m_wen=0.
REQ-010 SHALL drive write_data as st_data replicated into the selected lanes (byte {4{b}}, half {2{h}}, word unchanged); 0 when no store.
REQ-011 SHALL return memory loads combinationally, zero latency, no stall: byte/half extracted from m_rdata by addr[1:0] and zero-extended.
REQ-012 SHALL pass in_data and btn_raw through per-bit two-flop synchronizers before any use.
REQ-013 SHALL implement FSM IDLE, IO_RD, RESP: IDLE->IO_RD on aligned mapped IO read; IO_RD->RESP unconditionally; RESP->IDLE unconditionally.
REQ-014 SHALL assert stall combinationally in IDLE on an accepted IO read, and registered in IO_RD; stall=0 in RESP (IO read latency 2 cycles, 2 stall cycles).
REQ-015 SHALL capture the selected synchronized value into rd_buf on IDLE->IO_RD and drive r_wdata=rd_buf in RESP; request inputs held during stall are ignored in IO_RD and RESP.
REQ-016 SHALL set sticky btn_flag on a synchronized btn rising edge; button read returns {31'b0,btn_flag} and clears it in RESP; a new edge in the clear cycle wins (flag stays 1).
REQ-017 SHALL, on an aligned IO word write to output k in IDLE, load out_data[k] with st_data at the next edge and pulse out_strobe[k] high for exactly that one cycle.
REQ-018 SHALL ignore unmapped or misaligned accesses (no write, r_wdata=0, no stall) and pulse addr_err one cycle.
REQ-019 SHALL give m_read priority when m_read and m_write are both high: perform the read, drop the write, pulse addr_err.
REQ-020 SHALL drive r_wdata=0 whenever no load completes in that cycle.

Reset
REQ-021 SHALL, with rst_n=0 at a clk edge: FSM to IDLE; rd_buf, btn_flag, synchronizers, out_data, out_strobe, addr_err to 0; stall=0 the following cycle, including mid-IO_RD or RESP (read abandoned).

Structure
REQ-022 SHALL take IO_BASE_HI, offset constants (input base, 8'h70, 8'h80) and FSM state encodings from shared header io_header.
REQ-023 SHALL instantiate sub-module sync_2ff (parametrised width) for in_data and btn_raw synchronization.

Verification
REQ-024 Word load addr=32'h0000_0010, m_rdata=32'hDEAD_BEEF -> r_wdata=32'hDEAD_BEEF same cycle, stall=0.
REQ-025 Byte store addr=32'h0000_0003, st_data=32'h0000_00A5 -> byte_en=4'b1000, write_data=32'hA5A5_A5A5, m_wen=1.
REQ-026 in_data ch1=32'h0000_0ABC stable 3 cycles, load addr=32'hFFFF_FC04 -> stall 2 cycles, r_wdata=32'h0000_0ABC in third cycle.
REQ-027 Store 32'h0000_FFFF to 32'hFFFF_FC84 -> out_data ch1=32'h0000_FFFF next cycle, out_strobe=2'b10 one cycle.
REQ-028 btn_raw pulse, then load 32'hFFFF_FC70 twice -> returns 1 then 0; edge during clear cycle -> second read returns 1.
REQ-029 rst_n=0 during IO_RD -> stall=0 next cycle, r_wdata=0, out_data=0; half load at 32'h0000_0001 -> addr_err pulse, no stall.
